// File: rtl/alt_vipvfr120_vfr_frame_sequencer_pkg.sv
// Shared types and constants for the VFR frame sequencer and its packet tracker.
package vfr_seq_pkg;

  // Frame-level controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_CTRL,
    ST_CMD,
    ST_STREAM
  } seq_state_e;

  // Position of the packet tracker within the current frame's packets.
  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_WAIT_SOP,
    TRK_CTRL,
    TRK_VIDEO
  } trk_phase_e;

  // Avalon-ST video packet type nibbles.
  localparam logic [3:0] VFR_CTRL_TYPE  = 4'hF;
  localparam logic [3:0] VFR_VIDEO_TYPE = 4'h0;

  // Inter-frame gap counter width; holds FRAME_GAP values up to 15.
  localparam int GAP_WIDTH = 4;

  // Programmed frame geometry, kept both as shadow and as committed copy.
  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlaced;
  } frame_cfg_t;

  // Full 32-bit pixel count of a frame; never truncated.
  function automatic logic [31:0] frame_words(input logic [15:0] w, input logic [15:0] h);
    return 32'(w) * 32'(h);
  endfunction

  // The encoder always emits its control packet first, so the first sop of a
  // frame carries the control type and every later sop carries video.
  function automatic logic [3:0] sop_packet_type(input logic ctrl_seen);
    return ctrl_seen ? VFR_VIDEO_TYPE : VFR_CTRL_TYPE;
  endfunction

  // Interlace nibble sent to the encoder: bit2 becomes the field parity
  // whenever bit3 marks the stream as interlaced.
  function automatic logic [3:0] encode_interlace(input logic [3:0] nibble, input logic parity);
    return nibble[3] ? {nibble[3], parity, nibble[1:0]} : nibble;
  endfunction

endpackage

// File: rtl/alt_vipvfr120_vfr_frame_sequencer_if.sv
// Fetch-command handshake and encoder-output stream taps of the frame sequencer.
interface alt_vipvfr120_vfr_frame_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_words;
  logic                  vid_valid;
  logic                  vid_ready;
  logic                  vid_sop;
  logic                  vid_eop;

  // Sequencer side: issues the command, observes the stream.
  modport master (
    output cmd_valid, cmd_addr, cmd_words,
    input  cmd_ready, vid_valid, vid_ready, vid_sop, vid_eop
  );

  // Read master / stream side.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_words,
    output cmd_ready, vid_valid, vid_ready, vid_sop, vid_eop
  );
endinterface

// File: rtl/alt_vipvfr120_vfr_packet_tracker.sv
// Follows the encoder output stream of one frame: skips the control packet
// and flags the beats and the eop that belong to the video packet.
module alt_vipvfr120_vfr_packet_tracker
  import vfr_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic vid_valid,
  input  logic vid_ready,
  input  logic vid_sop,
  input  logic vid_eop,
  output logic video_active,
  output logic pixel_beat,
  output logic video_eop
);

  trk_phase_e phase;
  logic       ctrl_seen;
  logic       beat;
  logic [3:0] sop_type;

  assign beat     = vid_valid & vid_ready;
  assign sop_type = sop_packet_type(ctrl_seen);

  // Decode beat qualifiers for the sequencer from the current phase.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    video_active = (phase == TRK_VIDEO);
    pixel_beat   = beat & ~vid_sop;
    video_eop    = 1'b0;
    if (beat && vid_eop) begin
      if (phase == TRK_VIDEO) begin
        video_eop = 1'b1;
      end else if (phase == TRK_WAIT_SOP && vid_sop && sop_type != VFR_CTRL_TYPE) begin
        video_eop = 1'b1;
      end
    end
  end

  // Walk control packet -> video packet; arm restarts the walk for a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= TRK_IDLE;
      ctrl_seen <= 1'b0;
    end else if (arm) begin
      phase     <= TRK_WAIT_SOP;
      ctrl_seen <= 1'b0;
    end else if (beat) begin
      case (phase)
        TRK_WAIT_SOP: begin
          if (vid_sop) begin
            if (sop_type == VFR_CTRL_TYPE) begin
              ctrl_seen <= 1'b1;
              phase     <= vid_eop ? TRK_WAIT_SOP : TRK_CTRL;
            end else begin
              phase <= vid_eop ? TRK_IDLE : TRK_VIDEO;
            end
          end
        end
        TRK_CTRL: begin
          if (vid_eop) phase <= TRK_WAIT_SOP;
        end
        TRK_VIDEO: begin
          if (vid_eop) phase <= TRK_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alt_vipvfr120_vfr_frame_sequencer.sv
// Per-frame controller of the VFR output path: commits geometry, triggers the
// control packet, issues the pixel fetch and closes the frame on its eop.
module alt_vipvfr120_vfr_frame_sequencer
  import vfr_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FRAME_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_go,
  input  logic                  cfg_update,
  input  logic [15:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  input  logic [3:0]            cfg_interlaced,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic                  do_control_packet,
  output logic [15:0]           width,
  output logic [15:0]           height,
  output logic [3:0]            interlaced,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_cfg,
  output logic                  err_len,
  input  logic                  err_clear,
  alt_vipvfr120_vfr_frame_sequencer_if.master bus
);

  seq_state_e            state;
  frame_cfg_t            shadow;
  logic [ADDR_WIDTH-1:0] shadow_addr;
  logic                  cfg_blocked;
  logic                  parity;
  logic                  parity_commit;
  logic [GAP_WIDTH-1:0]  gap_count;
  logic [31:0]           pixel_count;
  logic [31:0]           pixel_count_next;
  logic                  count_beat;
  logic                  trk_arm;
  logic                  video_active;
  logic                  pixel_beat;
  logic                  video_eop;

  // The tracker restarts while the control packet is being requested, so any
  // sop it sees afterwards belongs to this frame.
  assign trk_arm = (state == ST_CTRL);

  alt_vipvfr120_vfr_packet_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .arm          (trk_arm),
    .vid_valid    (bus.vid_valid),
    .vid_ready    (bus.vid_ready),
    .vid_sop      (bus.vid_sop),
    .vid_eop      (bus.vid_eop),
    .video_active (video_active),
    .pixel_beat   (pixel_beat),
    .video_eop    (video_eop)
  );

  // Pixel count including the current beat, so the eop beat itself is counted.
  always_comb begin
    count_beat       = video_active & pixel_beat;
    pixel_count_next = pixel_count + 32'(count_beat);
  end

  // Parity restarts at 0 whenever the committed interlace mode flips.
  assign parity_commit = (shadow.interlaced[3] == interlaced[3]) ? parity : 1'b0;

  // Frame sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      shadow            <= '0;
      shadow_addr       <= '0;
      cfg_blocked       <= 1'b0;
      parity            <= 1'b0;
      gap_count         <= '0;
      pixel_count       <= '0;
      do_control_packet <= 1'b0;
      width             <= '0;
      height            <= '0;
      interlaced        <= '0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      frame_count       <= '0;
      err_cfg           <= 1'b0;
      err_len           <= 1'b0;
      bus.cmd_valid     <= 1'b0;
      bus.cmd_addr      <= '0;
      bus.cmd_words     <= '0;
    end else begin
      do_control_packet <= 1'b0;
      frame_done        <= 1'b0;

      if (cfg_update) begin
        shadow      <= frame_cfg_t'{width: cfg_width, height: cfg_height, interlaced: cfg_interlaced};
        shadow_addr <= cfg_addr;
      end

      // NOTE: the last non-blocking assignment to a register wins, so an error
      // set in the case below overrides this clear in the same cycle.
      if (err_clear) begin
        err_cfg <= 1'b0;
        err_len <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (gap_count != '0) begin
            gap_count <= gap_count - GAP_WIDTH'(1);
          end else if (cfg_go && !cfg_blocked) begin
            state         <= ST_COMMIT;
            busy          <= 1'b1;
            width         <= shadow.width;
            height        <= shadow.height;
            interlaced    <= encode_interlace(shadow.interlaced, parity_commit);
            parity        <= parity_commit;
            bus.cmd_addr  <= shadow_addr;
            bus.cmd_words <= frame_words(shadow.width, shadow.height);
          end
        end

        ST_COMMIT: begin
          if (width == '0 || height == '0) begin
            err_cfg     <= 1'b1;
            cfg_blocked <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            do_control_packet <= 1'b1;
            state             <= ST_CTRL;
          end
        end

        ST_CTRL: begin
          pixel_count   <= '0;
          bus.cmd_valid <= 1'b1;
          state         <= ST_CMD;
        end

        ST_CMD: begin
          if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            state         <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (count_beat) pixel_count <= pixel_count_next;
          if (video_eop) begin
            if (pixel_count_next != bus.cmd_words) err_len <= 1'b1;
            if (interlaced[3]) parity <= ~parity;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            gap_count   <= GAP_WIDTH'(FRAME_GAP);
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // A fresh configuration releases a commit blocked by zero geometry.
      if (cfg_update) cfg_blocked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alt_vipvfr120_vfr_frame_sequencer.sv
// Directed self-checking bench for the VFR frame sequencer.
module tb_alt_vipvfr120_vfr_frame_sequencer;

  localparam int ADDR_WIDTH = 32;
  localparam int FRAME_GAP  = 2;
  localparam int BUDGET     = 40;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_go;
  logic                  cfg_update;
  logic [15:0]           cfg_width;
  logic [15:0]           cfg_height;
  logic [3:0]            cfg_interlaced;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic                  do_control_packet;
  logic [15:0]           width;
  logic [15:0]           height;
  logic [3:0]            interlaced;
  logic                  busy;
  logic                  frame_done;
  logic [15:0]           frame_count;
  logic                  err_cfg;
  logic                  err_len;
  logic                  err_clear;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int dones       = 0;

  alt_vipvfr120_vfr_frame_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  alt_vipvfr120_vfr_frame_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .FRAME_GAP  (FRAME_GAP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_go            (cfg_go),
    .cfg_update        (cfg_update),
    .cfg_width         (cfg_width),
    .cfg_height        (cfg_height),
    .cfg_interlaced    (cfg_interlaced),
    .cfg_addr          (cfg_addr),
    .do_control_packet (do_control_packet),
    .width             (width),
    .height            (height),
    .interlaced        (interlaced),
    .busy              (busy),
    .frame_done        (frame_done),
    .frame_count       (frame_count),
    .err_cfg           (err_cfg),
    .err_len           (err_len),
    .err_clear         (err_clear),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  // Count pulse cycles mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (do_control_packet === 1'b1) pulses++;
    if (frame_done === 1'b1) dones++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cfg_go = 1'b0; cfg_update = 1'b0; err_clear = 1'b0;
    bus.cmd_ready = 1'b0; bus.vid_valid = 1'b0; bus.vid_ready = 1'b0;
    bus.vid_sop = 1'b0; bus.vid_eop = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic program_cfg(input logic [15:0] w, input logic [15:0] h,
                             input logic [3:0] il, input logic [31:0] a);
    cfg_width = w; cfg_height = h; cfg_interlaced = il; cfg_addr = a;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
  endtask

  task automatic beat(input logic sop, input logic eop);
    bus.vid_valid = 1'b1; bus.vid_ready = 1'b1; bus.vid_sop = sop; bus.vid_eop = eop;
    step();
    bus.vid_valid = 1'b0; bus.vid_ready = 1'b0; bus.vid_sop = 1'b0; bus.vid_eop = 1'b0;
  endtask

  // Valid without ready: must not be taken as a beat even with eop set.
  task automatic stall();
    bus.vid_valid = 1'b1; bus.vid_ready = 1'b0; bus.vid_sop = 1'b0; bus.vid_eop = 1'b1;
    step();
    bus.vid_valid = 1'b0; bus.vid_eop = 1'b0;
  endtask

  task automatic send_ctrl();
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
  endtask

  task automatic send_video(input int n);
    beat(1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      beat(1'b0, i == n - 1);
      if (i == 0) stall();
    end
  endtask

  task automatic wait_cmd(input string what);
    int n;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < BUDGET) begin
      step();
      n++;
    end
    vectors++;
    if (n >= BUDGET) begin
      miscompares++;
      $display("FAIL %s_cmd_timeout: cmd_valid=%b after %0d cycles, required 1", what, bus.cmd_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    vectors++;
    if ({do_control_packet, bus.cmd_valid, busy, frame_done, err_cfg, err_len} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 000000",
               {do_control_packet, bus.cmd_valid, busy, frame_done, err_cfg, err_len});
    end
    vectors++;
    if ({width, height, interlaced} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_geometry: got %h/%h/%h required 0", width, height, interlaced);
    end
    vectors++;
    if (bus.cmd_addr !== '0 || bus.cmd_words !== 32'h0 || frame_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_cmd: addr %h words %h count %h required 0", bus.cmd_addr, bus.cmd_words, frame_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int base_p, base_d, n;
    do_reset();
    base_p = pulses; base_d = dones;
    bus.cmd_ready = 1'b1;
    program_cfg(16'd4, 16'd2, 4'h0, 32'h1000_0000);
    cfg_go = 1'b1;
    wait_cmd("nominal");
    vectors++;
    if (pulses - base_p != 1) begin
      miscompares++;
      $display("FAIL nominal_pulses: got %0d required 1", pulses - base_p);
    end
    vectors++;
    if (bus.cmd_words !== 32'd8 || bus.cmd_addr !== 32'h1000_0000) begin
      miscompares++;
      $display("FAIL nominal_cmd: words %0d addr %h required 8 10000000", bus.cmd_words, bus.cmd_addr);
    end
    vectors++;
    if (width !== 16'd4 || height !== 16'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL nominal_geom: w %0d h %0d busy %b required 4 2 1", width, height, busy);
    end
    step();
    send_ctrl();
    send_video(8);
    vectors++;
    if (frame_done !== 1'b1 || frame_count !== 16'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_done: done %b count %0d busy %b required 1 1 0", frame_done, frame_count, busy);
    end
    vectors++;
    if (err_len !== 1'b0 || err_cfg !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_errors: len %b cfg %b required 0 0", err_len, err_cfg);
    end
    n = 0;
    while (do_control_packet !== 1'b1 && n < BUDGET) begin
      step();
      n++;
    end
    vectors++;
    if (n < FRAME_GAP + 1 || n >= BUDGET) begin
      miscompares++;
      $display("FAIL nominal_gap: next pulse %0d cycles after frame_done, required >= %0d", n, FRAME_GAP + 1);
    end
    vectors++;
    if (dones - base_d != 1) begin
      miscompares++;
      $display("FAIL nominal_done_width: got %0d cycles required 1", dones - base_d);
    end
  endtask

  task automatic test_backpressure();
    int base_p, valid_cycles;
    do_reset();
    base_p = pulses;
    program_cfg(16'd3, 16'd5, 4'h0, 32'hABCD_0040);
    cfg_go = 1'b1;
    wait_cmd("backpressure");
    valid_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.cmd_valid === 1'b1 && bus.cmd_addr === 32'hABCD_0040 && bus.cmd_words === 32'd15)
        valid_cycles++;
      if (i == 5) bus.cmd_ready = 1'b1;
      step();
    end
    vectors++;
    if (valid_cycles != 6 || bus.cmd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hold: stable valid cycles %0d valid_after %b required 6 0", valid_cycles, bus.cmd_valid);
    end
    vectors++;
    if (pulses - base_p != 1) begin
      miscompares++;
      $display("FAIL bp_pulses: got %0d required 1", pulses - base_p);
    end
    cfg_go = 1'b0;
    send_ctrl();
    send_video(15);
    vectors++;
    if (frame_count !== 16'd1 || err_len !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_frame: count %0d len %b required 1 0", frame_count, err_len);
    end
  endtask

  task automatic test_update_mid_frame();
    do_reset();
    bus.cmd_ready = 1'b1;
    program_cfg(16'd4, 16'd2, 4'h0, 32'h0000_2000);
    cfg_go = 1'b1;
    wait_cmd("update1");
    step();
    program_cfg(16'd8, 16'd2, 4'h0, 32'h0000_3000);
    vectors++;
    if (width !== 16'd4 || bus.cmd_words !== 32'd8) begin
      miscompares++;
      $display("FAIL update_hold: w %0d words %0d required 4 8", width, bus.cmd_words);
    end
    send_ctrl();
    send_video(8);
    vectors++;
    if (err_len !== 1'b0 || frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL update_frame1: len %b done %b required 0 1", err_len, frame_done);
    end
    wait_cmd("update2");
    vectors++;
    if (width !== 16'd8 || bus.cmd_words !== 32'd16 || bus.cmd_addr !== 32'h0000_3000) begin
      miscompares++;
      $display("FAIL update_frame2: w %0d words %0d addr %h required 8 16 00003000",
               width, bus.cmd_words, bus.cmd_addr);
    end
    cfg_go = 1'b0;
  endtask

  task automatic test_interlaced();
    logic [3:0] il_exp [3];
    il_exp[0] = 4'h8; il_exp[1] = 4'hC; il_exp[2] = 4'h8;
    do_reset();
    bus.cmd_ready = 1'b1;
    program_cfg(16'd2, 16'd2, 4'b1000, 32'h0000_4000);
    cfg_go = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_cmd("interlaced");
      vectors++;
      if (interlaced !== il_exp[f]) begin
        miscompares++;
        $display("FAIL interlaced_field%0d: got %h required %h", f, interlaced, il_exp[f]);
      end
      step();
      if (f == 2) cfg_go = 1'b0;
      send_ctrl();
      send_video(4);
    end
    vectors++;
    if (frame_count !== 16'd3) begin
      miscompares++;
      $display("FAIL interlaced_count: got %0d required 3", frame_count);
    end
  endtask

  task automatic test_errors();
    int base_p;
    do_reset();
    base_p = pulses;
    bus.cmd_ready = 1'b1;
    program_cfg(16'd4, 16'd0, 4'h0, 32'h0000_5000);
    cfg_go = 1'b1;
    step(10);
    vectors++;
    if (err_cfg !== 1'b1 || busy !== 1'b0 || pulses - base_p != 0) begin
      miscompares++;
      $display("FAIL err_cfg_set: err %b busy %b pulses %0d required 1 0 0", err_cfg, busy, pulses - base_p);
    end
    program_cfg(16'd4, 16'd2, 4'h0, 32'h0000_5000);
    wait_cmd("errors");
    cfg_go = 1'b0;
    step();
    send_ctrl();
    send_video(7);
    vectors++;
    if (err_len !== 1'b1 || err_cfg !== 1'b1 || frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL err_len_set: len %b cfg %b count %0d required 1 1 1", err_len, err_cfg, frame_count);
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    vectors++;
    if (err_len !== 1'b0 || err_cfg !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: len %b cfg %b required 0 0", err_len, err_cfg);
    end
  endtask

  task automatic test_stop_reset();
    int base_p;
    do_reset();
    base_p = pulses;
    bus.cmd_ready = 1'b1;
    program_cfg(16'd2, 16'd2, 4'h0, 32'h0000_6000);
    cfg_go = 1'b1;
    wait_cmd("stop");
    step();
    cfg_go = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_busy_mid: got %b required 1", busy);
    end
    send_ctrl();
    send_video(4);
    vectors++;
    if (frame_done !== 1'b1 || frame_count !== 16'd1) begin
      miscompares++;
      $display("FAIL stop_finish: done %b count %0d required 1 1", frame_done, frame_count);
    end
    step(10);
    vectors++;
    if (busy !== 1'b0 || pulses - base_p != 1) begin
      miscompares++;
      $display("FAIL stop_idle: busy %b pulses %0d required 0 1", busy, pulses - base_p);
    end
    cfg_go = 1'b1;
    wait_cmd("restart");
    step();
    send_ctrl();
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    rst = 1'b1;
    step();
    vectors++;
    if ({do_control_packet, bus.cmd_valid, busy, frame_done, err_cfg, err_len} !== 6'b0 ||
        frame_count !== 16'h0 || width !== 16'h0 || bus.cmd_words !== 32'h0 || bus.cmd_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_stream: flags %b count %0d w %0d words %0d addr %h required all 0",
               {do_control_packet, bus.cmd_valid, busy, frame_done, err_cfg, err_len},
               frame_count, width, bus.cmd_words, bus.cmd_addr);
    end
    cfg_go = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_go = 1'b0; cfg_update = 1'b0; err_clear = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_interlaced = '0; cfg_addr = '0;
    bus.cmd_ready = 1'b0; bus.vid_valid = 1'b0; bus.vid_ready = 1'b0;
    bus.vid_sop = 1'b0; bus.vid_eop = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_update_mid_frame();
    test_interlaced();
    test_errors();
    test_stop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
